// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed BCD scan driver with a double-buffered display value
// that only changes on frame boundaries, plus optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic {
    S_EMPTY,
    S_PENDING
  } load_state_t;

  load_state_t r_state;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_blank;
  logic          r_load_ready;
  logic          r_frame_done;

  logic          w_dwell_end;
  logic          w_wrap;
  logic [3:0]    w_digit;
  logic          w_blanked;

  assign w_dwell_end = (r_presc == PRESC_LAST);
  assign w_wrap      = w_dwell_end && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_dwell_end) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A value accepted on the wrap edge itself only becomes pending, so it
  // waits a full frame before it is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_load_ready <= 1'b1;
      r_pend       <= '0;
      r_disp       <= '0;
      r_frame_done <= 1'b0;
      r_blank      <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_blank      <= blank_lz;
      case (r_state)
        S_EMPTY: begin
          if (load_valid) begin
            r_pend       <= load_data;
            r_state      <= S_PENDING;
            r_load_ready <= 1'b0;
          end
        end
        S_PENDING: begin
          if (w_wrap) begin
            r_disp       <= r_pend;
            r_state      <= S_EMPTY;
            r_load_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_EMPTY;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_digit   = r_disp[3:0];
    w_blanked = 1'b0;
    case (r_idx)
      2'd0: w_digit = r_disp[3:0];
      2'd1: begin
        w_digit   = r_disp[7:4];
        w_blanked = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_digit   = r_disp[11:8];
        w_blanked = (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_digit   = r_disp[15:12];
        w_blanked = (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  assign bcd        = (r_blank && w_blanked) ? 4'hF : w_digit;
  assign digit_en   = 4'b0001 << r_idx;
  assign load_ready = r_load_ready;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at CLK_DIV=4: scan timing, frame-aligned
// loads, handshake back-pressure, leading-zero blanking and mid-frame reset.
module tb_seg_scan_driver;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_DIV(CLK_DIV)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // cyc counts active edges since reset release; each frame is 16 cycles.
  task automatic scan_check();
    logic [3:0] exp_en;
    exp_en = 4'b0001 << ((cyc / 4) % 4);
    check("digit_en", {12'h0, digit_en}, {12'h0, exp_en});
    check("frame_done", {15'h0, frame_done}, {15'h0, (cyc > 0) && (cyc % 16 == 0)});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit_en", {12'h0, digit_en}, 16'h0001);
    check("rst_bcd", {12'h0, bcd}, 16'h0000);
    check("rst_ready", {15'h0, load_ready}, 16'h0001);
    check("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    rst_n = 1'b1;
    cyc = 0;

    for (int k = 0; k <= 20; k++) begin
      run_to(k);
      scan_check();
      check("bcd_idle", {12'h0, bcd}, 16'h0000);
    end

    check("ready_before_load", {15'h0, load_ready}, 16'h0001);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    load_data  = '0;
    check("ready_drop", {15'h0, load_ready}, 16'h0000);
    for (int k = 21; k <= 31; k++) begin
      run_to(k);
      scan_check();
      check("bcd_no_tear", {12'h0, bcd}, 16'h0000);
    end
    run_to(32);
    check("ready_after_wrap", {15'h0, load_ready}, 16'h0001);
    check("frame_done_32", {15'h0, frame_done}, 16'h0001);
    check("bcd_1234_d0", {12'h0, bcd}, 16'h0004);
    run_to(36); check("bcd_1234_d1", {12'h0, bcd}, 16'h0003);
    run_to(40); check("bcd_1234_d2", {12'h0, bcd}, 16'h0002);
    run_to(44); check("bcd_1234_d3", {12'h0, bcd}, 16'h0001);

    // Second value held on the bus while the first is pending.
    run_to(50);
    load_valid = 1'b1;
    load_data  = 16'h0050;
    tick();
    check("ready_pend1", {15'h0, load_ready}, 16'h0000);
    load_data = 16'hABCD;
    run_to(60);
    blank_lz = 1'b1;
    check("bcd_1234_late", {12'h0, bcd}, 16'h0001);
    run_to(63);
    check("ready_held", {15'h0, load_ready}, 16'h0000);
    tick();
    check("ready_commit1", {15'h0, load_ready}, 16'h0001);
    check("frame_done_64", {15'h0, frame_done}, 16'h0001);
    check("blank_0050_d0", {12'h0, bcd}, 16'h0000);
    tick();
    check("ready_pend2", {15'h0, load_ready}, 16'h0000);
    load_valid = 1'b0;
    load_data  = '0;
    run_to(68); check("blank_0050_d1", {12'h0, bcd}, 16'h0005);
    run_to(72); check("blank_0050_d2", {12'h0, bcd}, 16'h000F);
    run_to(73);
    blank_lz = 1'b0;
    check("blank_latency_hold", {12'h0, bcd}, 16'h000F);
    tick();
    check("blank_off_d2", {12'h0, bcd}, 16'h0000);
    blank_lz = 1'b1;
    tick();
    check("blank_on_d2", {12'h0, bcd}, 16'h000F);
    run_to(76); check("blank_0050_d3", {12'h0, bcd}, 16'h000F);

    run_to(80);
    check("bcd_abcd_d0", {12'h0, bcd}, 16'h000D);
    check("ready_commit2", {15'h0, load_ready}, 16'h0001);
    run_to(82);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    tick();
    load_valid = 1'b0;
    run_to(84); check("bcd_abcd_d1", {12'h0, bcd}, 16'h000C);
    run_to(88); check("bcd_abcd_d2", {12'h0, bcd}, 16'h000B);
    run_to(92); check("bcd_abcd_d3", {12'h0, bcd}, 16'h000A);

    run_to(96);  check("blank_0000_d0", {12'h0, bcd}, 16'h0000);
    run_to(100); check("blank_0000_d1", {12'h0, bcd}, 16'h000F);
    run_to(104); check("blank_0000_d2", {12'h0, bcd}, 16'h000F);
    run_to(108); check("blank_0000_d3", {12'h0, bcd}, 16'h000F);
    blank_lz = 1'b0;
    run_to(110); check("noblank_0000_d3", {12'h0, bcd}, 16'h0000);

    // Reset lands while 9999 is still pending.
    run_to(114);
    load_valid = 1'b1;
    load_data  = 16'h9999;
    tick();
    load_valid = 1'b0;
    load_data  = '0;
    run_to(120);
    check("pre_rst_digit_en", {12'h0, digit_en}, 16'h0004);
    check("pre_rst_ready", {15'h0, load_ready}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {15'h0, load_ready}, 16'h0001);
    check("mid_rst_digit_en", {12'h0, digit_en}, 16'h0001);
    check("mid_rst_bcd", {12'h0, bcd}, 16'h0000);
    check("mid_rst_frame_done", {15'h0, frame_done}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k <= 32; k++) begin
      run_to(k);
      scan_check();
      check("bcd_after_rst", {12'h0, bcd}, 16'h0000);
      check("ready_after_rst", {15'h0, load_ready}, 16'h0001);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clock cycles each digit is displayed before the scan advances; legal range 2..65535.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_valid  input  1  high when new display value is offered.
REQ-006 SHALL have port load_data  input  16  four BCD digits; [3:0] digit0 (least significant) through [15:12] digit3.
REQ-007 SHALL have port load_ready  output  1  high when a new value can be accepted.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL have port bcd  output  4  BCD code of the currently scanned digit, fed to the BCD-to-7-segment decoder.
REQ-010 SHALL have port digit_en  output  4  one-hot active-high digit select; bit i selects digit i.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after each complete 4-digit scan.

Function
REQ-012 SHALL hold a prescaler counting 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-013 SHALL make one frame exactly 4*CLK_DIV cycles; digit_en SHALL equal 1<<index at every cycle.
REQ-014 SHALL implement a two-state load FSM: EMPTY (load_ready=1) and PENDING (load_ready=0); load_ready SHALL be a registered state, not a function of load_valid.
REQ-015 SHALL accept load_data into a pending register on any edge with load_valid=1 and load_ready=1, moving EMPTY->PENDING.
REQ-016 SHALL commit pending data to the display register only on the frame-wrap edge (prescaler=CLK_DIV-1 and index=3), moving PENDING->EMPTY on that edge.
REQ-017 SHALL, when a load is accepted on a frame-wrap edge in EMPTY, treat it as pending; it commits at the next frame wrap, not the current one.
REQ-018 SHALL never change the displayed value mid-frame (no tearing).
REQ-019 SHALL drive frame_done high for exactly the one cycle following each frame-wrap edge, whether or not a commit occurred.
REQ-020 SHALL pass digit codes 10..15 through unchanged on bcd; no range checking.
REQ-021 SHALL, when blank_lz=1, output bcd=4'hF for digit k (k=3,2,1) if display digits 3..k are all zero; digit0 is never blanked.
REQ-022 SHALL derive bcd and digit_en only from registered state (index, display register, registered blank_lz); no combinational path from any input to any output.
REQ-023 SHALL register blank_lz every cycle; its effect appears one cycle after it changes.

Reset
REQ-024 SHALL, while rst_n=0, force: prescaler=0, index=0, display register=16'h0000, pending register=16'h0000, FSM=EMPTY, blank_lz register=0.
REQ-025 SHALL therefore present during reset: digit_en=4'b0001, bcd=4'h0, load_ready=1, frame_done=0.
REQ-026 SHALL discard any pending, uncommitted value on reset, including reset asserted mid-frame.
REQ-027 SHALL start the first post-reset frame at digit0 with a full CLK_DIV-cycle dwell.

Verification (CLK_DIV=4)
REQ-028 Reset release, no loads -> digit_en cycles 0001,0010,0100,1000 with 4 cycles each; frame_done pulses every 16 cycles; bcd=0 throughout.
REQ-029 Load 16'h1234 mid-frame -> load_ready drops the next cycle; digits still show 0 until frame wrap; next frame shows bcd 4,3,2,1 on digit0..3; load_ready returns to 1 after the wrap.
REQ-030 blank_lz=1, display 16'h0050 -> digit3=F, digit2=F, digit1=5, digit0=0; display 16'h0000 -> F,F,F,0; blank_lz=0 -> 0,0,5,0.
REQ-031 Hold load_valid=1 with a second value while PENDING -> second value is not accepted until load_ready=1; first value is displayed for one full frame before the second.
REQ-032 Load 16'h9999, then assert rst_n=0 at index 2 before the wrap -> after release, display is 0000, load_ready=1, digit_en=0001; 9999 is never shown.
REQ-033 Load 16'hABCD -> bcd shows D,C,B,A unchanged; downstream decoder blanks them.
